// File: rtl/branch_pht.sv
// Pattern history table of 2-bit saturating counters plus a saturating mispredict counter.
// Optional gshare indexing is enabled with the BRANCH_PHT_GSHARE_EN macro.
module branch_pht #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_BITS   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [31:0]           i_pred_pc,
  output logic                  o_pred_taken,
  output logic [1:0]            o_pred_state,
  input  logic                  i_upd_valid,
  input  logic [31:0]           i_upd_pc,
  input  logic                  i_upd_taken,
  input  logic                  i_upd_pred_taken,
`ifdef BRANCH_PHT_GSHARE_EN
  output logic [INDEX_BITS-1:0] o_pred_ghr,
  input  logic [INDEX_BITS-1:0] i_upd_ghr,
`endif
  output logic                  o_upd_mispredict,
  output logic [CNT_BITS-1:0]   o_miss_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            r_table [ENTRIES];
  logic [CNT_BITS-1:0]   r_miss_cnt;
  logic                  r_mispredict;
  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic [1:0]            w_old;
  logic [1:0]            w_next;
  logic                  w_miss;

`ifdef BRANCH_PHT_GSHARE_EN
  logic [INDEX_BITS-1:0] r_ghr;

  assign w_rd_idx   = i_pred_pc[INDEX_BITS+1:2] ^ r_ghr;
  assign w_wr_idx   = i_upd_pc[INDEX_BITS+1:2] ^ i_upd_ghr;
  assign o_pred_ghr = r_ghr;

  // History is rebuilt from the branch's own fetch-time snapshot, which repairs it after a mispredict.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ghr <= '0;
    end else if (i_upd_valid) begin
      r_ghr <= {i_upd_ghr[INDEX_BITS-2:0], i_upd_taken};
    end
  end
`else
  assign w_rd_idx = i_pred_pc[INDEX_BITS+1:2];
  assign w_wr_idx = i_upd_pc[INDEX_BITS+1:2];
`endif

  assign o_pred_state = r_table[w_rd_idx];
  assign o_pred_taken = o_pred_state[1];
  assign w_old        = r_table[w_wr_idx];
  assign w_miss       = i_upd_valid & (i_upd_taken != i_upd_pred_taken);

  always_comb begin
    w_next = w_old;
    if (i_upd_taken) begin
      if (w_old != 2'b11) w_next = w_old + 2'd1;
    end else begin
      if (w_old != 2'b00) w_next = w_old - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_table      <= '{default: INIT_STATE};
      r_miss_cnt   <= '0;
      r_mispredict <= 1'b0;
    end else begin
      if (i_upd_valid) begin
        r_table[w_wr_idx] <= w_next;
      end
      r_mispredict <= w_miss;
      if (w_miss && (r_miss_cnt != {CNT_BITS{1'b1}})) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign o_upd_mispredict = r_mispredict;
  assign o_miss_cnt       = r_miss_cnt;

endmodule
